dmem_responder: RTL and testbench

Word-addressed data-memory responder that serves the load/store requests issued by the MIPS datapath (its `aluout` address, `writedata` store data, and the `memwrite` strobe from control). It holds a DEPTH-word RAM, accepts one request at a time over a valid/ready handshake, and inserts a programmable number of wait states before returning one response pulse. The core stalls on `req_ready`/`rsp_valid`, which makes a multi-cycle memory possible behind the existing single-cycle datapath.

---
 rtl/dmem_responder.sv | 190 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Word-addressed data-memory responder for the MIPS datapath. Accepts one
// load/store request at a time over a valid/ready handshake, waits LATENCY
// clock edges, performs the memory operation, then pulses rsp_valid for
// exactly one cycle. The core stalls on req_ready / rsp_valid.
//
// Parameters
//   DEPTH    number of 32-bit words held in the RAM (word index = addr[31:2])
//   LATENCY  wait states between accept and the memory operation, 0..15
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset (RAM contents are preserved)
//   req_valid  request present
//   req_ready  responder can accept a request this cycle (IDLE)
//   req_we     1 = store word, 0 = load word
//   req_addr   byte address
//   req_wdata  store data
//   rsp_valid  one-cycle response pulse (RESP)
//   rsp_rdata  load data, registered; held until the next memory operation
//   rsp_err    misaligned / out-of-range flag, registered and held likewise
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  cnt_reg;

    logic [31:0] ram [DEPTH];

    logic        accept;
    logic        op_fire;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_err;
    logic [IDX_W-1:0] op_idx;

    assign accept = (state_reg == IDLE) && req_valid;

    // Source of the memory operation. With zero latency the operation happens
    // on the accept edge straight from the request bus; otherwise the request
    // is captured on accept and replayed when the wait counter expires.
    generate
        if (LATENCY == 0) begin : g_direct
            assign op_fire  = accept;
            assign op_we    = req_we;
            assign op_addr  = req_addr;
            assign op_wdata = req_wdata;
        end else begin : g_latched
            logic        we_reg;
            logic [31:0] addr_reg;
            logic [31:0] wdata_reg;

            // Capture registers need no reset: they are only consumed after
            // an accept has loaded them.
            always_ff @(posedge clk) begin
                if (accept) begin
                    we_reg    <= req_we;
                    addr_reg  <= req_addr;
                    wdata_reg <= req_wdata;
                end
            end

            assign op_fire  = (state_reg == WAIT) && (cnt_reg == 4'd1);
            assign op_we    = we_reg;
            assign op_addr  = addr_reg;
            assign op_wdata = wdata_reg;
        end
    endgenerate

    assign op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:2] >= 30'(DEPTH));
    assign op_idx = op_addr[IDX_W+1:2];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE:    req_ready = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Wait-state counter: loaded on accept, counts down while waiting.
    // The 1->0 transition is the operation edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= 4'd0;
        end else if (accept) begin
            cnt_reg <= 4'(LATENCY);
        end else if ((state_reg == WAIT) && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Response registers. Reset takes priority over a coincident operation
    // edge, so a reset on that edge also suppresses the result.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (op_fire) begin
            rsp_err <= op_err;
            if (op_err || op_we) begin
                rsp_rdata <= 32'd0;
            end else begin
                rsp_rdata <= ram[op_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM write port. Contents are never reset; a reset on the operation
    // edge drops the pending store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && op_fire && op_we && !op_err) begin
            ram[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Three responders with LATENCY 2, 0 and 3 share one clock and reset. Each is
// driven through its own request bus and compared against a word-array model
// of the memory plus the accept-to-response timing rule.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int N     = 3;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic        req_ready [N];
    logic        rsp_valid [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    int nassert = 0;
    int nfail   = 0;
    int edges   = 0;

    logic [31:0] mem_m [N][DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    function automatic int lat_of(input int i);
        if (i == 0) return 2;
        if (i == 1) return 0;
        return 3;
    endfunction

    function automatic bit addr_err(input logic [31:0] addr);
        logic [29:0] w;
        w = addr[31:2];
        return (addr[1:0] != 2'b00) || (w >= 30'(DEPTH));
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s u%0d: observed %h expected %h", tag, i, obs, exp);
        end
    endtask

    // Wait (bounded) at a negedge until instance i is ready.
    task automatic wait_ready(input int i);
        int waited;
        waited = 0;
        while (req_ready[i] !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_wait", i, {31'd0, req_ready[i]}, 32'd1);
    endtask

    // One full transaction. Called at a negedge; returns at the negedge of the
    // first cycle in which req_ready is high again, with req_valid dropped.
    task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit noise, output int acc_edge);
        int          lat;
        bit          err;
        logic [31:0] exp_rd;
        lat      = lat_of(i);
        acc_edge = -1;
        wait_ready(i);
        if (req_ready[i] !== 1'b1) return;
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        err    = addr_err(addr);
        exp_rd = 32'd0;
        if (!err) begin
            if (we) mem_m[i][int'(addr[31:2])] = wdata;
            else    exp_rd = mem_m[i][int'(addr[31:2])];
        end
        @(posedge clk);
        #1 acc_edge = edges;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            chk("rsp_valid", i, {31'd0, rsp_valid[i]}, {31'd0, (c == lat)});
            chk("req_ready", i, {31'd0, req_ready[i]}, {31'd0, (c == lat + 1)});
            if (c >= lat) begin
                chk("rsp_err", i, {31'd0, rsp_err[i]}, {31'd0, err});
                chk("rsp_rdata", i, rsp_rdata[i], exp_rd);
            end
            if (noise && c < lat + 1) begin
                // Garbage on the bus while busy: must be neither served nor written.
                req_valid[i] = 1'b1;
                req_we[i]    = 1'($urandom_range(0, 1));
                req_addr[i]  = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
                req_wdata[i] = $urandom;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic check_reset_values(input int i);
        chk("rst_rsp_valid", i, {31'd0, rsp_valid[i]}, 32'd0);
        chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
        chk("rst_rsp_err", i, {31'd0, rsp_err[i]}, 32'd0);
        chk("rst_req_ready", i, {31'd0, req_ready[i]}, 32'd1);
    endtask

    // Store, then reset sampled on edge E0+k. The store lands only if its
    // operation edge E0+lat came strictly before the reset edge.
    task automatic rst_mid(input int i, input logic [31:0] addr, input logic [31:0] wdata, input int k);
        wait_ready(i);
        if (req_ready[i] !== 1'b1) return;
        req_valid[i] = 1'b1;
        req_we[i]    = 1'b1;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        @(posedge clk);
        for (int e = 1; e <= k; e++) begin
            @(negedge clk);
            req_valid[i] = 1'b0;
            if (e == k) reset = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b0;
        if (k > lat_of(i) && !addr_err(addr)) mem_m[i][int'(addr[31:2])] = wdata;
        for (int j = 0; j < N; j++) check_reset_values(j);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", i, {31'd0, rsp_valid[i]}, 32'd0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          prev;
        int          kind;
        logic [31:0] a;

        reset = 1'b1;
        for (int j = 0; j < N; j++) begin
            req_valid[j] = 1'b0;
            req_we[j]    = 1'b0;
            req_addr[j]  = 32'd0;
            req_wdata[j] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < N; j++) check_reset_values(j);

        // Directed: LATENCY=2 store then load.
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, acc);
        prev = acc;
        do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, acc);
        chk("b2b_gap", 0, 32'(acc - prev), 32'd4);

        // Directed: LATENCY=0 store then immediate load.
        do_req(1, 1'b1, 32'h0, 32'h12345678, 1'b0, acc);
        prev = acc;
        do_req(1, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        chk("b2b_gap", 1, 32'(acc - prev), 32'd2);

        // Fill every word of every instance so later loads have known data.
        for (int j = 0; j < N; j++)
            for (int w = 0; w < DEPTH; w++)
                do_req(j, 1'b1, 32'(w * 4), $urandom, 1'b0, acc);

        // Error cases.
        do_req(0, 1'b0, 32'h13, 32'h0, 1'b0, acc);
        do_req(0, 1'b1, 32'h100, 32'hBAD0BAD0, 1'b0, acc);
        do_req(0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
        do_req(2, 1'b1, 32'h2, 32'h0BADF00D, 1'b0, acc);
        do_req(2, 1'b0, 32'h0, 32'h0, 1'b0, acc);

        // Busy-period bus noise with req_valid held high.
        for (int j = 0; j < N; j++) begin
            do_req(j, 1'b0, 32'h24, 32'h0, 1'b1, acc);
            do_req(j, 1'b1, 32'h28, $urandom, 1'b1, acc);
        end
        for (int j = 0; j < N; j++)
            for (int w = 0; w < DEPTH; w++)
                do_req(j, 1'b0, 32'(w * 4), 32'h0, 1'b0, acc);

        // Reset mid-request, including the specific CAFEF00D drop on LATENCY=3.
        rst_mid(2, 32'h20, 32'hCAFEF00D, 1);
        do_req(2, 1'b0, 32'h20, 32'h0, 1'b0, acc);
        for (int j = 0; j < N; j++) begin
            for (int k = 1; k <= lat_of(j) + 1; k++) begin
                a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
                rst_mid(j, a, $urandom, k);
                do_req(j, 1'b0, a, 32'h0, 1'b0, acc);
            end
        end

        // Randomized traffic with back-to-back spacing checks.
        for (int j = 0; j < N; j++) begin
            prev = -1;
            for (int t = 0; t < 40; t++) begin
                kind = int'($urandom_range(0, 19));
                if (kind < 14)      a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
                else if (kind < 17) a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                else                a = 32'($urandom_range(DEPTH, 4000)) << 2;
                do_req(j, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0), acc);
                if (prev >= 0) chk("b2b_gap", j, 32'(acc - prev), 32'(lat_of(j) + 2));
                prev = acc;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
